// File: rtl/alu_seq_param_if.sv
// Pad-side bus for alu_seq_param: operand loads, op/start handshake and result pins.
interface alu_seq_param_if #(parameter int W = 8);
  logic [W-1:0]   in_data;
  logic           load_a;
  logic           load_b;
  logic [2:0]     op;
  logic [1:0]     flag_sel;
  logic           start;
  logic           busy;
  logic           done;
  logic [2*W-1:0] result;
  logic           flag;
  logic           overflow;

  modport master (output in_data, load_a, load_b, op, flag_sel, start,
                  input  busy, done, result, flag, overflow);
  modport slave  (input  in_data, load_a, load_b, op, flag_sel, start,
                  output busy, done, result, flag, overflow);
endinterface

// File: rtl/alu_seq_param.sv
// Sequential W-bit ALU: single-cycle add/sub/logic/shift, iterative shift-add
// multiply and restoring divide over W clocks, registered 2W-bit result and status.
module alu_seq_param #(parameter int W = 8) (
  input  logic          clk,
  input  logic          rst,
  alu_seq_param_if.slave bus
);
  localparam int CW = $clog2(W);
  localparam logic [0:0] S_IDLE = 1'b0, S_ITER = 1'b1;
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3,
                         OP_XOR = 3'd4, OP_SHL = 3'd5, OP_MUL = 3'd6, OP_DIV = 3'd7;

  logic [W-1:0]   a_q, b_q, opnd_q, hi_q, lo_q;
  logic [2:0]     op_q;
  logic [0:0]     state_q;
  logic [CW-1:0]  cnt_q;
  logic [2*W-1:0] res_q;
  logic           ovf_q, done_q, z_q, c_q, n_q, p_q;

  logic [W:0]     sum, diff, mul_sum, div_sh, div_tr;
  logic [2*W-1:0] sc_res, fin_res;
  logic           sc_c, sc_v, fin_v, fin_n, fin_en, start_ok, iter_op, last_iter;
  logic [W-1:0]   hi_nx, lo_nx;

  // Single-cycle results use the pre-edge operand registers directly.
  always_comb begin
    sc_res = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    sum    = {1'b0, a_q} + {1'b0, b_q};
    diff   = {1'b0, a_q} - {1'b0, b_q};
    case (bus.op)
      OP_ADD: begin
        sc_res = {{(W-1){1'b0}}, sum};
        sc_c   = sum[W];
        sc_v   = (a_q[W-1] == b_q[W-1]) && (sum[W-1] != a_q[W-1]);
      end
      OP_SUB: begin
        sc_res = {{W{1'b0}}, diff[W-1:0]};
        sc_c   = diff[W];
        sc_v   = (a_q[W-1] != b_q[W-1]) && (diff[W-1] != a_q[W-1]);
      end
      OP_AND: sc_res = {{W{1'b0}}, a_q & b_q};
      OP_OR:  sc_res = {{W{1'b0}}, a_q | b_q};
      OP_XOR: sc_res = {{W{1'b0}}, a_q ^ b_q};
      OP_SHL: sc_res = {{W{1'b0}}, a_q} << b_q[CW-1:0];
      OP_DIV: begin
        sc_res = {a_q, {W{1'b1}}};
        sc_v   = 1'b1;
      end
      default: ;
    endcase
  end

  // MUL: hi/lo = running product / multiplier. DIV: hi/lo = remainder / quotient.
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_sh  = {hi_q, lo_q[W-1]};
    div_tr  = div_sh - {1'b0, opnd_q};
    if (op_q == OP_MUL) begin
      hi_nx = mul_sum[W:1];
      lo_nx = {mul_sum[0], lo_q[W-1:1]};
    end else if (!div_tr[W]) begin
      hi_nx = div_tr[W-1:0];
      lo_nx = {lo_q[W-2:0], 1'b1};
    end else begin
      hi_nx = div_sh[W-1:0];
      lo_nx = {lo_q[W-2:0], 1'b0};
    end
  end

  assign start_ok  = bus.start && (state_q == S_IDLE);
  assign iter_op   = (bus.op == OP_MUL) || ((bus.op == OP_DIV) && (b_q != '0));
  assign last_iter = (state_q == S_ITER) && (cnt_q == CW'(W-1));
  assign fin_en    = (start_ok && !iter_op) || last_iter;
  assign fin_res   = (state_q == S_ITER) ? {hi_nx, lo_nx} : sc_res;
  assign fin_v     = (state_q == S_ITER) ? ((op_q == OP_MUL) && (hi_nx != '0)) : sc_v;
  assign fin_n     = ((state_q == S_ITER) && (op_q == OP_MUL)) ? fin_res[2*W-1] : fin_res[W-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0; b_q <= '0; opnd_q <= '0; hi_q <= '0; lo_q <= '0;
      op_q <= OP_ADD; state_q <= S_IDLE; cnt_q <= '0;
      res_q <= '0; ovf_q <= 1'b0; done_q <= 1'b0;
      z_q <= 1'b0; c_q <= 1'b0; n_q <= 1'b0; p_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.load_a) a_q <= bus.in_data;
      if (bus.load_b) b_q <= bus.in_data;
      if (start_ok && iter_op) begin
        state_q <= S_ITER;
        op_q    <= bus.op;
        cnt_q   <= '0;
        opnd_q  <= (bus.op == OP_MUL) ? a_q : b_q;
        hi_q    <= '0;
        lo_q    <= (bus.op == OP_MUL) ? b_q : a_q;
      end else if (state_q == S_ITER) begin
        hi_q  <= hi_nx;
        lo_q  <= lo_nx;
        cnt_q <= cnt_q + 1'b1;
        if (last_iter) state_q <= S_IDLE;
      end
      if (fin_en) begin
        done_q <= 1'b1;
        res_q  <= fin_res;
        ovf_q  <= fin_v;
        z_q    <= (fin_res == '0);
        c_q    <= (state_q == S_ITER) ? 1'b0 : sc_c;
        n_q    <= fin_n;
        p_q    <= ^fin_res;
      end
    end
  end

  always_comb begin
    case (bus.flag_sel)
      2'b00:   bus.flag = z_q;
      2'b01:   bus.flag = c_q;
      2'b10:   bus.flag = n_q;
      default: bus.flag = p_q;
    endcase
  end

  assign bus.busy     = (state_q == S_ITER);
  assign bus.done     = done_q;
  assign bus.result   = res_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_alu_seq_param.sv
// Directed + small random bench for alu_seq_param (W=8) with an expected-result queue.
module tb_alu_seq_param;
  localparam int W = 8;

  typedef struct {
    string       tag;
    logic [15:0] res;
    logic        ovf;
    logic [3:0]  fl;   // {P,N,C,Z}
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  alu_seq_param_if #(.W(W)) bus();
  alu_seq_param #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk); bus.in_data = a; bus.load_a = 1'b1;
    @(negedge clk); bus.in_data = b; bus.load_a = 1'b0; bus.load_b = 1'b1;
    @(negedge clk); bus.load_b = 1'b0;
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e; int sa, sb_, r; logic [15:0] res; logic [7:0] d; logic c, v;
    sa = int'($signed(a)); sb_ = int'($signed(b)); c = 1'b0; v = 1'b0; res = '0;
    case (op)
      3'd0: begin res = 16'(a) + 16'(b); c = res[8]; r = sa + sb_; v = (r > 127) || (r < -128); end
      3'd1: begin d = a - b; res = {8'h00, d}; c = (a < b); r = sa - sb_; v = (r > 127) || (r < -128); end
      3'd2: res = {8'h00, a & b};
      3'd3: res = {8'h00, a | b};
      3'd4: res = {8'h00, a ^ b};
      default: res = 16'(a) << (b % 8);
    endcase
    e.tag = $sformatf("rand_op%0d", op); e.res = res; e.ovf = v;
    e.fl = {^res, res[7], c, res == 16'h0}; e.lat = 1;
    return e;
  endfunction

  // Push expectation, fire start, wait (bounded) for done, pop and compare.
  task automatic run_op(input logic [2:0] op, input exp_t e, input bit poke);
    exp_t g; int lat;
    sb.push_back(e);
    @(negedge clk); bus.op = op; bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0; lat = 1;
    while (!bus.done && lat < 40) begin
      @(negedge clk); lat++;
      if (poke && lat == 3) begin bus.in_data = 8'h05; bus.load_a = 1'b1; bus.start = 1'b1; end
      else if (poke && lat == 4) begin bus.load_a = 1'b0; bus.start = 1'b0; end
    end
    g = sb.pop_front();
    chk({g.tag, ".done"}, 32'(bus.done), 32'd1);
    chk({g.tag, ".latency"}, 32'(lat), 32'(g.lat));
    chk({g.tag, ".result"}, 32'(bus.result), 32'(g.res));
    chk({g.tag, ".overflow"}, 32'(bus.overflow), 32'(g.ovf));
    for (int s = 0; s < 4; s++) begin
      bus.flag_sel = 2'(s); #1;
      chk($sformatf("%s.flag%0d", g.tag, s), 32'(bus.flag), 32'(g.fl[s]));
    end
    @(negedge clk);
    chk({g.tag, ".done_clear"}, 32'(bus.done), 32'd0);
  endtask

  function automatic exp_t mk(input string tag, input logic [15:0] res, input logic ovf,
                              input logic [3:0] fl, input int lat);
    exp_t e;
    e.tag = tag; e.res = res; e.ovf = ovf; e.fl = fl; e.lat = lat;
    return e;
  endfunction

  initial begin
    int seen; logic [7:0] ra, rb; logic [2:0] rop;
    bus.in_data = '0; bus.load_a = 1'b0; bus.load_b = 1'b0;
    bus.op = '0; bus.flag_sel = '0; bus.start = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.busy", 32'(bus.busy), 32'd0);
    chk("rst.done", 32'(bus.done), 32'd0);
    chk("rst.result", 32'(bus.result), 32'd0);
    chk("rst.overflow", 32'(bus.overflow), 32'd0);
    for (int s = 0; s < 4; s++) begin
      bus.flag_sel = 2'(s); #1;
      chk($sformatf("rst.flag%0d", s), 32'(bus.flag), 32'd0);
    end
    rst = 1'b0;

    load(8'd128, 8'd218);
    run_op(3'd0, mk("add", 16'h015A, 1'b1, 4'b1010, 1), 1'b0);
    run_op(3'd1, mk("sub", 16'h00A6, 1'b0, 4'b0110, 1), 1'b0);
    run_op(3'd6, mk("mul_poke", 16'h6D00, 1'b1, 4'b1000, W + 1), 1'b1);
    chk("mul_poke.busy_after", 32'(bus.busy), 32'd0);

    load(8'd218, 8'd128);
    run_op(3'd7, mk("div", 16'h5A01, 1'b0, 4'b1000, W + 1), 1'b0);
    load(8'd218, 8'd0);
    run_op(3'd7, mk("div0", 16'hDAFF, 1'b1, 4'b1100, 1), 1'b0);
    load(8'h81, 8'd12);
    run_op(3'd5, mk("shl", 16'h0810, 1'b0, 4'b0000, 1), 1'b0);
    load(8'h0F, 8'hF0);
    run_op(3'd2, mk("and", 16'h0000, 1'b0, 4'b0001, 1), 1'b0);

    for (int i = 0; i < 6; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rop = 3'($urandom_range(0, 5));
      load(ra, rb);
      run_op(rop, model(rop, ra, rb), 1'b0);
    end

    // Abort a multiply three cycles in with reset.
    load(8'd128, 8'd218);
    @(negedge clk); bus.op = 3'd6; bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort.busy_before", 32'(bus.busy), 32'd1);
    rst = 1'b1; #1;
    chk("abort.busy", 32'(bus.busy), 32'd0);
    chk("abort.done", 32'(bus.done), 32'd0);
    chk("abort.result", 32'(bus.result), 32'd0);
    bus.flag_sel = 2'b11; #1;
    chk("abort.flag", 32'(bus.flag), 32'd0);
    @(negedge clk); rst = 1'b0;
    seen = 0;
    repeat (12) begin @(negedge clk); if (bus.done) seen++; end
    chk("abort.no_done", 32'(seen), 32'd0);
    load(8'd1, 8'd1);
    run_op(3'd0, mk("add_after_rst", 16'h0002, 1'b0, 4'b1000, 1), 1'b0);

    chk("scoreboard.empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_seq_param.md
# alu_seq_param

Parametrised sequential ALU, the next generation of the team's 8-bit TinyTapeout ALU. It latches two W-bit operands from a shared input bus. Single-cycle arithmetic, logic and shift ops complete in one clock; multiply and divide are iterative over W cycles, behind a start/busy/done handshake. It produces a 2W-bit registered result, a selectable status flag and an overflow indication, and sits between the pad-level input bus and the output pins.

## Interface
- W, default 8: operand width; power of two, 4..32.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  W  shared operand bus.
- load_a  in  1  capture in_data into operand register A on the clock edge.
- load_b  in  1  capture in_data into operand register B on the clock edge.
- op  in  3  operation select, sampled with start.
- flag_sel  in  2  live status-flag select: 00 zero, 01 carry/borrow, 10 negative, 11 parity.
- start  in  1  begin the operation; honoured only while busy=0.
- busy  out  1  multi-cycle op in progress.
- done  out  1  one-cycle pulse: result and status just updated.
- result  out  2W  registered result; holds until the next completion.
- flag  out  1  status bit chosen by flag_sel.
- overflow  out  1  registered overflow/error for the last completed op.

## Operation
- A and B load independently. When both load strobes are high, both take in_data. Loads are accepted while busy.
- On an accepted start, op, A and B are snapshotted. Later loads do not affect the running op.
- Ops and results (upper bits zero-filled unless stated):
  - 000 ADD: {carry, A+B}. C = carry out. overflow = signed overflow.
  - 001 SUB: A−B mod 2^W. C = borrow (A<B unsigned). overflow = signed overflow.
  - 010 AND, 011 OR, 100 XOR: bitwise. C=0, overflow=0.
  - 101 SHL: A << (B mod W), kept in full 2W bits, no loss. C=0, overflow=0.
  - 110 MUL: unsigned shift-add, 2W-bit product. C=0. overflow = (product[2W-1:W] ≠ 0).
  - 111 DIV: unsigned restoring divide; result = {remainder, quotient}. C=0, overflow=0.
- DIV with B=0: completes as a single-cycle op. result = {A, all-ones}, overflow=1.
- Status bits are registered at completion:
  - Z = (result == 0), over all 2W bits.
  - N = result[W-1]; for MUL, N = result[2W-1].
  - P = XOR of all 2W result bits.
- flag is a combinational mux of the registered Z/C/N/P by the current flag_sel.
- State machine:
  - IDLE: on start, a single-cycle op (or DIV with B=0) completes and stays in IDLE; MUL or DIV with B≠0 goes to ITER.
  - ITER: one iteration per clock, with a counter 0..W-1. After the W-th iteration, go to IDLE and pulse done.
- start while busy=1 is ignored: no queueing, no effect on the running op.

## Timing
- Reset values: busy=0, done=0, result=0, overflow=0, Z/C/N/P=0 (flag=0), A=B=0, state IDLE, counter 0.
- Let start be sampled at edge E0.
  - Single-cycle ops: result, status and done=1 are visible after E0. done clears after E1.
  - MUL/DIV: busy=1 after E0. Iterations occur on E1..EW. After EW: busy=0, done=1, result and status updated.
  - A new start is accepted at EW itself only if busy was already 0; in practice that means from E(W+1).
- result, status and overflow change only on a done pulse or on reset.
- rst asserted mid-ITER: immediate abort. All outputs go to reset values, no done pulse. The next start after reset release behaves normally.
- start and load on the same edge: the snapshot uses the pre-edge A/B values.

## Test plan (W=8)
- Load A=128 (load_a), B=218 (load_b), ADD -> after 1 cycle result=0x015A, done pulse, C=1, overflow=1, Z=0.
- Same operands, SUB -> result=0x00A6, C=1 (borrow), N=1, overflow=0.
- Same operands, MUL -> busy high for exactly 8 cycles, then result=0x6D00, overflow=1, P=1 via flag_sel=11. Change A mid-run and pulse start -> result unchanged, no restart.
- DIV A=218, B=128 -> after 8 cycles result=0x5A01. Then DIV with B=0 -> after 1 cycle result=0xDAFF, overflow=1.
- SHL A=0x81, B=12 (shift 4) -> result=0x0810. AND A=0x0F, B=0xF0 -> result=0, flag_sel=00 gives flag=1.
- Assert rst 3 cycles into MUL -> busy, done, result and flag all 0 immediately, with no later done pulse. A following ADD 1+1 gives result=0x0002.
